// File: rtl/wide_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wide_add_sequencer_pkg
//  Purpose  : Shared constants and state encoding for the multi-precision
//             add sequencer and its bench.
//  Revision : 1.0 - initial release
// ============================================================================
package wide_add_sequencer_pkg;

  // Width of one adder-stage slice.
  localparam int NIBBLE_W = 4;

  // Cycles from driving the adder stage to its registered sum/carry.
  localparam int ADD_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/wide_add_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : wide_add_sequencer_if
//  Purpose  : Request/result handshake plus the link to the external 4-bit
//             registered adder stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface wide_add_sequencer_if
  import wide_add_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  // Request side
  logic                start;
  logic [W-1:0]        a;
  logic [W-1:0]        b;
  logic                cin;
  logic                ready;
  // Result side
  logic                res_valid;
  logic                res_ready;
  logic [W-1:0]        sum;
  logic                cout;
  logic                ovf;
  // Adder-stage link
  logic [NIBBLE_W-1:0] add_x;
  logic [NIBBLE_W-1:0] add_y;
  logic                add_cin;
  logic [NIBBLE_W-1:0] add_z;
  logic                add_cout;

  // Sequencer side
  modport slave (
    input  start, a, b, cin, res_ready, add_z, add_cout,
    output ready, res_valid, sum, cout, ovf, add_x, add_y, add_cin
  );

  // Parent side: requester plus the adder stage
  modport master (
    output start, a, b, cin, res_ready, add_z, add_cout,
    input  ready, res_valid, sum, cout, ovf, add_x, add_y, add_cin
  );

endinterface
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : wide_add_sequencer
//  Purpose  : Chains an external registered 4-bit adder nibble by nibble to
//             produce a 4*NIBBLES-bit sum, carry and signed overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wide_add_sequencer_if.slave  bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [W-1:0]          a_q, b_q;
  logic                  cin_q;
  logic                  carry_q;
  logic                  cout_q;
  logic                  ovf_q;
  logic [NIBBLE_W-1:0]   sum_slice_q [NIBBLES];
  logic [NIBBLE_W-1:0]   a_nib [NIBBLES];
  logic [NIBBLE_W-1:0]   b_nib [NIBBLES];
  logic [W-1:0]          sum_w;
  logic                  issue_cin;

  // Slice 0 starts from the request carry; later slices chain the stage's carry.
  assign issue_cin = (k_q == '0) ? cin_q : bus.add_cout;

  // Per-slice operand views, result assembly and write-enable decode.
  for (genvar i = 0; i < NIBBLES; i++) begin : g_slice
    logic we;
    assign a_nib[i] = a_q[i*NIBBLE_W +: NIBBLE_W];
    assign b_nib[i] = b_q[i*NIBBLE_W +: NIBBLE_W];
    assign sum_w[i*NIBBLE_W +: NIBBLE_W] = sum_slice_q[i];
    // Slice i lands while slice i+1 issues; the top slice lands in CAPTURE.
    assign we = ((state_q == S_ISSUE) && (int'(k_q) == i + 1)) ||
                ((state_q == S_CAPTURE) && (i == NIBBLES - 1));

    // Result slice register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_slice_q[i] <= '0;
      end else if (we) begin
        sum_slice_q[i] <= bus.add_z;
      end
    end
  end

  // State and slice-index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          k_d     = '0;
        end
      end
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (k_q == KW'(NIBBLES - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = S_ISSUE;
        end
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand latch, held carry, and final carry/overflow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && bus.start) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        cin_q <= bus.cin;
      end
      if (state_q == S_ISSUE) begin
        carry_q <= issue_cin;
      end
      if (state_q == S_CAPTURE) begin
        cout_q <= bus.add_cout;
        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (bus.add_z[NIBBLE_W-1] != a_q[W-1]);
      end
    end
  end

  // Adder-stage drive: the operands are presented in ISSUE and held through WAIT.
  always_comb begin
    bus.add_x   = '0;
    bus.add_y   = '0;
    bus.add_cin = 1'b0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      bus.add_x = a_nib[k_q];
      bus.add_y = b_nib[k_q];
    end
    if (state_q == S_ISSUE) begin
      bus.add_cin = issue_cin;
    end else if (state_q == S_WAIT) begin
      bus.add_cin = carry_q;
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.sum       = sum_w;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-precision add controller that sits directly around the registered 4-bit carry-look-ahead adder stage. It feeds that stage one nibble pair per step and consumes its registered sum and carry-out. It chains the carry nibble by nibble and assembles a 4·NIBBLES-bit result, delivered through a valid/ready handshake. The adder stage itself stays external and is connected by the parent.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when ready=1.
- a  in  W  operand A; sampled at acceptance.
- b  in  W  operand B; sampled at acceptance.
- cin  in  1  carry-in of the whole add; sampled at acceptance.
- ready  out  1  block is IDLE and will accept start.
- res_valid  out  1  result available; held until res_ready.
- res_ready  in  1  consumer accepts the result.
- sum  out  W  result, low nibble at [3:0].
- cout  out  1  carry-out of the top nibble.
- ovf  out  1  signed overflow of the two's-complement add.
- add_x  out  4  nibble of A to the adder stage.
- add_y  out  4  nibble of B to the adder stage.
- add_cin  out  1  carry to the adder stage.
- add_z  in  4  registered sum from the adder stage.
- add_cout  in  1  registered carry from the adder stage.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE. Slice index k runs from 0 to NIBBLES-1.
- IDLE
  - ready=1; add_x, add_y and add_cin are driven 0.
  - On start=1: latch a, b and cin; set k=0; go to ISSUE.
- ISSUE(k)
  - Drive add_x=a[4k+3:4k] and add_y=b[4k+3:4k].
  - add_cin = latched cin if k=0, otherwise add_cout.
  - If k>0: register add_z into sum slice k-1.
  - Go to WAIT.
- WAIT
  - Hold the same add_x, add_y and add_cin.
  - If k<NIBBLES-1: increment k and go to ISSUE; otherwise go to CAPTURE.
- CAPTURE
  - Register add_z into the top slice and add_cout into cout.
  - ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), computed from the latched operands.
  - Go to DONE.
- DONE
  - res_valid=1; sum, cout and ovf are held stable.
  - On res_ready=1: go to IDLE.
- start is ignored in every state except IDLE, including DONE with res_ready=1 in the same cycle.
- Arithmetic is modulo 2^W plus cout; no saturation.
- Adder-stage flops have no reset. Their stale contents are never sampled, because capture happens only two cycles after a matching ISSUE.

## Timing
- Adder-stage latency is fixed at 2 cycles: inputs driven in cycle t give add_z/add_cout valid in cycle t+2.
- With start accepted in cycle 0:
  - ISSUE(k) occurs in cycle 1+2k.
  - CAPTURE occurs in cycle 2·NIBBLES+1.
  - res_valid rises in cycle 2·NIBBLES+2 (cycle 10 for NIBBLES=4).
- Throughput: one add per 2·NIBBLES+3 cycles when res_ready=1 at DONE entry.
- Reset values: state=IDLE, ready=1, res_valid=0, sum=0, cout=0, ovf=0, add_x=0, add_y=0, add_cin=0.
- Reset asserted mid-operation:
  - The operation is abandoned immediately.
  - The adder stage may still flush old data; it is ignored.
  - The first start after reset release behaves exactly as from power-up.
- Reset dominates a simultaneous start or res_ready.

## Structure
- Shared package holds:
  - nibble width constant (4);
  - state enumeration (IDLE, ISSUE, WAIT, CAPTURE, DONE);
  - the adder-stage latency constant (2), used for the timing assertions.
- Single module; the slice index drives a nibble-select mux and a nibble write-enable decode. No sub-module is needed.
- The adder stage is instantiated beside this block in the parent, not inside it.

## Test plan
- Reset, then idle 3 cycles -> ready=1, res_valid=0, sum=0, cout=0, ovf=0, add_x=add_y=0.
- a=0x1234, b=0x0FFF, cin=0 -> sum=0x2233, cout=0, ovf=0; res_valid first high in cycle 10 after acceptance.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry ripples through all 4 slices.
- a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Result held with res_ready=0 for 5 cycles while start pulses -> sum/cout/ovf stable, start ignored; ready returns the cycle after res_ready=1.
- rst pulsed during cycle 5 of an add -> all outputs at reset values; the next add 0x00FF+0x0001 gives sum=0x0100 with correct timing.
